hwpe_ctrl_uloop_seq: RTL and testbench
======================================

HWPE_CTRL_ULOOP_SEQ -- requirements
Module: hwpe_ctrl_uloop_seq

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the tile counter.
REQ-002 Parameter TIMEOUT, default 64: maximum WAIT_UL cycles before error; 0 disables the watchdog.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 test_mode_i  in  1  test mode; no functional effect.
REQ-006 clear_i  in  1  synchronous soft clear.
REQ-007 start_i  in  1  job start pulse.
REQ-008 uloop_enable_o  out  1  single-cycle request for the next microloop update.
REQ-009 uloop_clear_o  out  1  single-cycle microloop clear.
REQ-010 uloop_valid_i  in  1  microloop flags valid, i.e. the update completed.
REQ-011 uloop_done_i  in  1  microloop reports that all loops are exhausted; sampled only with uloop_valid_i.
REQ-012 stream_req_o  out  1  request to launch streamers with the current offsets.
REQ-013 stream_ack_i  in  1  streamer accept.
REQ-014 compute_done_i  in  1  engine finished the current tile.
REQ-015 busy_o  out  1  a job is in progress.
REQ-016 done_o  out  1  single-cycle job-complete event.
REQ-017 error_o  out  1  sticky watchdog error.
REQ-018 tile_cnt_o  out  CNT_WIDTH  number of tiles completed in the current job.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, LAUNCH, COMPUTE, UPDATE, WAIT_UL, FINISH and ERROR.
REQ-020 IDLE:
- start_i SHALL move to CLEAR.
- tile_cnt_o SHALL be zeroed.
- error_o SHALL be cleared.
REQ-021 CLEAR:
- uloop_clear_o=1 for exactly one cycle.
- Unconditional transition to LAUNCH.
REQ-022 LAUNCH:
- stream_req_o=1 and held until the cycle stream_ack_i=1.
- On stream_ack_i=1 SHALL move to COMPUTE.
- A request with ack in the same cycle completes in one cycle.
REQ-023 COMPUTE:
- Wait for compute_done_i=1.
- On compute_done_i=1: tile_cnt_o SHALL increment and the FSM SHALL move to UPDATE.
REQ-024 UPDATE:
- uloop_enable_o=1 for exactly one cycle.
- Unconditional transition to WAIT_UL.
- The watchdog counter SHALL be reset to 0.
REQ-025 WAIT_UL:
- On uloop_valid_i=1 with uloop_done_i=1: move to FINISH.
- On uloop_valid_i=1 with uloop_done_i=0: move to LAUNCH.
- Otherwise the watchdog counter SHALL increment.
REQ-026 Watchdog (TIMEOUT>0): if the counter reaches TIMEOUT-1 without uloop_valid_i, the FSM SHALL move to ERROR; uloop_valid_i in that same cycle takes priority.
REQ-027 FINISH:
- done_o=1 for exactly one cycle.
- Then move to IDLE.
- tile_cnt_o SHALL be held until the next start.
REQ-028 ERROR:
- error_o=1 and busy_o=1.
- Exit only through clear_i or reset.
REQ-029 busy_o SHALL be 1 in every state except IDLE.
REQ-030 Inputs outside their state SHALL be ignored:
- start_i when not in IDLE;
- stream_ack_i outside LAUNCH;
- compute_done_i outside COMPUTE;
- uloop_valid_i outside WAIT_UL.
REQ-031 tile_cnt_o SHALL wrap modulo 2^CNT_WIDTH without flagging.
REQ-032 clear_i SHALL take priority over every transition:
- next state IDLE;
- all outputs 0;
- tile_cnt_o and the watchdog counter zeroed.
REQ-033 All outputs except tile_cnt_o SHALL be decoded from registered state only; there is no combinational input-to-output path.

Reset
REQ-034 While rst_ni=0 the block SHALL be in IDLE with every output and counter at 0, asynchronously.
REQ-035 Reset or clear_i asserted mid-job SHALL abort the job without a done_o pulse; the next start_i SHALL begin a fresh job.

Verification
REQ-036 Three-tile job, ack immediate: start_i pulse; microloop valid with done sequence 0,0,1 -> exactly 3 stream_req_o handshakes, 3 uloop_enable_o pulses, 1 uloop_clear_o pulse, done_o after the third valid, tile_cnt_o=3.
REQ-037 Backpressure: stream_ack_i delayed 5 cycles -> stream_req_o held high for 6 cycles, no duplicate launch.
REQ-038 Watchdog: TIMEOUT=8, uloop_valid_i never asserted -> ERROR entered on the 8th WAIT_UL cycle, error_o=1 sticky; clear_i -> IDLE with all outputs 0.
REQ-039 Spurious inputs: compute_done_i and uloop_valid_i pulsed while in LAUNCH, start_i pulsed while in COMPUTE -> no state change, tile_cnt_o unchanged.
REQ-040 Mid-job reset: rst_ni low during COMPUTE of tile 2 -> busy_o=0 and tile_cnt_o=0 immediately, no done_o; a new start_i completes normally.
REQ-041 Wrap: CNT_WIDTH=2, five-tile job -> tile_cnt_o=1 at done_o.

Source files
------------

// File: rtl/hwpe_ctrl_uloop_seq.sv
// Tile-level job sequencer: clears the microloop, then per tile launches the
// streamers, waits for compute, and steps the microloop until it reports done.
module hwpe_ctrl_uloop_seq #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_mode_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  output logic                 uloop_enable_o,
  output logic                 uloop_clear_o,
  input  logic                 uloop_valid_i,
  input  logic                 uloop_done_i,
  output logic                 stream_req_o,
  input  logic                 stream_ack_i,
  input  logic                 compute_done_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [CNT_WIDTH-1:0] tile_cnt_o
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LAUNCH, COMPUTE, UPDATE, WAIT_UL, FINISH, ERROR
  } state_e;

  state_e              state;
  logic [CNT_WIDTH-1:0] tile_cnt;
  logic [WD_W-1:0]      wd_cnt;

  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      tile_cnt <= '0;
      wd_cnt   <= '0;
    end else if (clear_i) begin
      state    <= IDLE;
      tile_cnt <= '0;
      wd_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state    <= CLEAR;
          tile_cnt <= '0;  // previous job's count stays visible until here
        end
        CLEAR:   state <= LAUNCH;
        LAUNCH:  if (stream_ack_i) state <= COMPUTE;
        COMPUTE: if (compute_done_i) begin
          state    <= UPDATE;
          tile_cnt <= tile_cnt + 1'b1;
        end
        UPDATE: begin
          state  <= WAIT_UL;
          wd_cnt <= '0;
        end
        WAIT_UL: begin
          // a valid arriving on the last watchdog cycle still wins
          if (uloop_valid_i)                     state  <= uloop_done_i ? FINISH : LAUNCH;
          else if (TIMEOUT > 0 && wd_cnt == WD_MAX) state <= ERROR;
          else                                    wd_cnt <= wd_cnt + 1'b1;
        end
        FINISH:  state <= IDLE;
        ERROR:   state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

  assign uloop_clear_o  = (state == CLEAR);
  assign stream_req_o   = (state == LAUNCH);
  assign uloop_enable_o = (state == UPDATE);
  assign done_o         = (state == FINISH);
  assign error_o        = (state == ERROR);
  assign busy_o         = (state != IDLE);
  assign tile_cnt_o     = tile_cnt;

endmodule

// File: tb/tb_hwpe_ctrl_uloop_seq.sv
// Bench for hwpe_ctrl_uloop_seq: acts as streamer, engine and microloop;
// expected tile counts are queued at job start and checked on done_o.
module tb_hwpe_ctrl_uloop_seq;
  localparam int CW = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_ni, test_mode_i, clear_i, start_i;
  logic uloop_enable_o, uloop_clear_o, uloop_valid_i, uloop_done_i;
  logic stream_req_o, stream_ack_i, compute_done_i;
  logic busy_o, done_o, error_o;
  logic [CW-1:0] tile_cnt_o;

  hwpe_ctrl_uloop_seq #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .clear_i(clear_i),
    .start_i(start_i), .uloop_enable_o(uloop_enable_o), .uloop_clear_o(uloop_clear_o),
    .uloop_valid_i(uloop_valid_i), .uloop_done_i(uloop_done_i),
    .stream_req_o(stream_req_o), .stream_ack_i(stream_ack_i),
    .compute_done_i(compute_done_i), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .tile_cnt_o(tile_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_req, n_en, n_clr, n_done;
  int exp_q[$];

  // monitor: handshake/pulse counters and done_o scoreboard
  always @(negedge clk) begin
    if (stream_req_o && stream_ack_i) n_req++;
    if (uloop_enable_o) n_en++;
    if (uloop_clear_o) n_clr++;
    if (done_o) begin
      int e;
      n_done++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected tile_cnt=%0d", tile_cnt_o);
      end else begin
        e = exp_q.pop_front();
        if (tile_cnt_o !== CW'(e)) begin
          failures++;
          $display("FAIL done_tile_cnt got=%0d exp=%0d", tile_cnt_o, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return stream_req_o;
      1: return uloop_enable_o;
      default: return error_o;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input string nm);
    int k = 0;
    while (sig(sel) !== 1'b1 && k < 100) begin step(); k++; end
    checks++;
    if (sig(sel) !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout got=0 exp=1", nm);
    end
  endtask

  task automatic clr_counts();
    n_req = 0; n_en = 0; n_clr = 0; n_done = 0;
  endtask

  // one tile from LAUNCH to the microloop response; returns req-high cycles
  task automatic do_tile(input bit last, input int ack_dly, output int req_hi);
    req_hi = 0;
    wait_sig(0, "stream_req");
    for (int d = 0; d < ack_dly; d++) begin
      if (stream_req_o) req_hi++;
      step();
    end
    stream_ack_i = 1'b1;
    if (stream_req_o) req_hi++;
    step();
    stream_ack_i = 1'b0;
    compute_done_i = 1'b1; step(); compute_done_i = 1'b0;
    wait_sig(1, "uloop_enable");
    step();
    uloop_valid_i = 1'b1; uloop_done_i = last; step();
    uloop_valid_i = 1'b0; uloop_done_i = 1'b0;
  endtask

  task automatic run_job(input int tiles, input int ack_dly, output int req_hi);
    int h;
    req_hi = 0;
    exp_q.push_back(tiles % (1 << CW));
    start_i = 1'b1; step(); start_i = 1'b0;
    for (int t = 0; t < tiles; t++) begin
      do_tile(t == tiles - 1, ack_dly, h);
      if (h > req_hi) req_hi = h;
    end
    step();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; #1;
    checks++;
    if ({busy_o, done_o, error_o, stream_req_o, uloop_enable_o, uloop_clear_o} !== 6'b0 ||
        tile_cnt_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b cnt=%0d exp=0", {busy_o, done_o, error_o}, tile_cnt_o);
    end
    step(); step();
    rst_ni = 1'b1; step();
  endtask

  task automatic test_three_tile();
    int h;
    clr_counts();
    run_job(3, 0, h);
    step();
    checks++; if (n_req !== 3) begin failures++; $display("FAIL three_req got=%0d exp=3", n_req); end
    checks++; if (n_en !== 3) begin failures++; $display("FAIL three_enable got=%0d exp=3", n_en); end
    checks++; if (n_clr !== 1) begin failures++; $display("FAIL three_clear got=%0d exp=1", n_clr); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL three_done got=%0d exp=1", n_done); end
    checks++; if (tile_cnt_o !== 2'd3 || busy_o !== 1'b0) begin
      failures++; $display("FAIL three_hold cnt=%0d busy=%b exp cnt=3 busy=0", tile_cnt_o, busy_o);
    end
  endtask

  task automatic test_backpressure();
    int h;
    clr_counts();
    run_job(1, 5, h);
    step();
    checks++; if (h !== 6) begin failures++; $display("FAIL bp_req_cycles got=%0d exp=6", h); end
    checks++; if (n_req !== 1) begin failures++; $display("FAIL bp_launches got=%0d exp=1", n_req); end
  endtask

  task automatic test_watchdog();
    int k = 0;
    clr_counts();
    start_i = 1'b1; step(); start_i = 1'b0;
    wait_sig(0, "wd_req");
    stream_ack_i = 1'b1; step(); stream_ack_i = 1'b0;
    compute_done_i = 1'b1; step(); compute_done_i = 1'b0;
    wait_sig(1, "wd_enable");
    while (error_o !== 1'b1 && k < 50) begin step(); k++; end
    checks++; if (k !== TO + 1) begin failures++; $display("FAIL wd_latency got=%0d exp=%0d", k, TO + 1); end
    repeat (5) step();
    checks++; if (error_o !== 1'b1 || busy_o !== 1'b1) begin
      failures++; $display("FAIL wd_sticky err=%b busy=%b exp=1,1", error_o, busy_o);
    end
    clear_i = 1'b1; step(); clear_i = 1'b0;
    checks++;
    if ({busy_o, done_o, error_o, stream_req_o, uloop_enable_o, uloop_clear_o} !== 6'b0 ||
        tile_cnt_o !== '0) begin
      failures++; $display("FAIL wd_clear outs=%b cnt=%0d exp=0", {busy_o, error_o}, tile_cnt_o);
    end
    checks++; if (n_done !== 0) begin failures++; $display("FAIL wd_no_done got=%0d exp=0", n_done); end
  endtask

  task automatic test_spurious();
    int h;
    clr_counts();
    exp_q.push_back(1);
    start_i = 1'b1; step(); start_i = 1'b0;
    wait_sig(0, "sp_req");
    compute_done_i = 1'b1; uloop_valid_i = 1'b1; uloop_done_i = 1'b1; step();
    compute_done_i = 1'b0; uloop_valid_i = 1'b0; uloop_done_i = 1'b0;
    checks++; if (stream_req_o !== 1'b1 || tile_cnt_o !== 2'd0) begin
      failures++; $display("FAIL sp_launch req=%b cnt=%0d exp req=1 cnt=0", stream_req_o, tile_cnt_o);
    end
    stream_ack_i = 1'b1; step(); stream_ack_i = 1'b0;
    start_i = 1'b1; step(); start_i = 1'b0; step();
    checks++;
    if (stream_req_o !== 1'b0 || uloop_clear_o !== 1'b0 || busy_o !== 1'b1 || tile_cnt_o !== 2'd0) begin
      failures++; $display("FAIL sp_compute req=%b clr=%b busy=%b cnt=%0d exp 0,0,1,0",
                           stream_req_o, uloop_clear_o, busy_o, tile_cnt_o);
    end
    compute_done_i = 1'b1; step(); compute_done_i = 1'b0;
    checks++; if (uloop_enable_o !== 1'b1 || tile_cnt_o !== 2'd1) begin
      failures++; $display("FAIL sp_update en=%b cnt=%0d exp en=1 cnt=1", uloop_enable_o, tile_cnt_o);
    end
    step();
    uloop_valid_i = 1'b1; uloop_done_i = 1'b1; step();
    uloop_valid_i = 1'b0; uloop_done_i = 1'b0;
    step(); step();
    checks++; if (n_done !== 1 || n_req !== 1) begin
      failures++; $display("FAIL sp_counts done=%0d req=%0d exp 1,1", n_done, n_req);
    end
    h = 0;
  endtask

  task automatic test_midjob_reset();
    int h;
    clr_counts();
    start_i = 1'b1; step(); start_i = 1'b0;
    do_tile(1'b0, 0, h);
    wait_sig(0, "mr_req");
    stream_ack_i = 1'b1; step(); stream_ack_i = 1'b0;
    step();
    rst_ni = 1'b0; #1;
    checks++; if (busy_o !== 1'b0 || tile_cnt_o !== 2'd0) begin
      failures++; $display("FAIL mr_async busy=%b cnt=%0d exp 0,0", busy_o, tile_cnt_o);
    end
    step(); rst_ni = 1'b1; step();
    checks++; if (n_done !== 0) begin failures++; $display("FAIL mr_no_done got=%0d exp=0", n_done); end
    run_job(2, 1, h);
    step();
    checks++; if (n_done !== 1 || tile_cnt_o !== 2'd2) begin
      failures++; $display("FAIL mr_rerun done=%0d cnt=%0d exp 1,2", n_done, tile_cnt_o);
    end
  endtask

  task automatic test_wrap();
    int h;
    run_job(5, 0, h);
    step();
    checks++; if (tile_cnt_o !== 2'd1) begin failures++; $display("FAIL wrap_cnt got=%0d exp=1", tile_cnt_o); end
  endtask

  initial begin
    test_mode_i = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    uloop_valid_i = 1'b0; uloop_done_i = 1'b0; stream_ack_i = 1'b0; compute_done_i = 1'b0;
    clr_counts();
    test_reset();
    test_three_tile();
    test_backpressure();
    test_watchdog();
    test_spurious();
    test_midjob_reset();
    test_wrap();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
